// File: rtl/win_checker.sv
// win_checker: scans a Connect-4 board one cell per clock in row-major order; WIN_CHECK_MASK_EN adds o_win_mask.
// done pulses k+1 edges after start (k = anchor index, ROWS*COLS with no win); start is ignored while busy.
module win_checker #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [0:ROWS-1][0:COLS-1][1:0] i_board,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [1:0]                     o_winner,
  output logic                           o_draw,
  output logic [2:0]                     o_win_row,
  output logic [2:0]                     o_win_col,
  output logic [1:0]                     o_win_dir
`ifdef WIN_CHECK_MASK_EN
  ,
  output logic [ROWS*COLS-1:0]           o_win_mask
`endif
);
  localparam int NCELL = ROWS * COLS;
  localparam int IW    = $clog2(NCELL);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [1:0]      r_winner, w_winner_nxt;
  logic            r_draw, w_draw_nxt;
  logic [RW-1:0]   r_win_row, w_win_row_nxt;
  logic [CW-1:0]   r_win_col, w_win_col_nxt;
  logic [1:0]      r_win_dir, w_win_dir_nxt;

  logic [NCELL*4-1:0] w_hit;
  logic [3:0]         w_cell_hit;
  logic [1:0]         w_dir;
  logic [COLS-1:0]    w_top_nz;

  // Per-cell, per-direction run detection; lines that would leave the board are never built.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      for (genvar d = 0; d < 4; d++) begin : g_dir
        localparam int DR = (d == 0) ? 0 : 1;
        localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
        localparam int ER = r + (WIN_LEN - 1) * DR;
        localparam int EC = c + (WIN_LEN - 1) * DC;
        if (ER < ROWS && EC >= 0 && EC < COLS) begin : g_in
          logic [WIN_LEN-1:0] w_eq;
          for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
            assign w_eq[k] = (i_board[r + k*DR][c + k*DC] == i_board[r][c]);
          end
          assign w_hit[(r*COLS + c)*4 + d] =
            ((i_board[r][c] == 2'd1) || (i_board[r][c] == 2'd2)) && (&w_eq);
        end else begin : g_out
          assign w_hit[(r*COLS + c)*4 + d] = 1'b0;
        end
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign w_top_nz[c] = |i_board[0][c];
  end

  assign w_cell_hit = 4'(w_hit >> {r_idx, 2'b00});
  assign w_dir = w_cell_hit[0] ? 2'd0 :
                 w_cell_hit[1] ? 2'd1 :
                 w_cell_hit[2] ? 2'd2 : 2'd3;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_winner_nxt  = r_winner;
    w_draw_nxt    = r_draw;
    w_win_row_nxt = r_win_row;
    w_win_col_nxt = r_win_col;
    w_win_dir_nxt = r_win_dir;
    case (r_state)
      SCAN: begin
        if (|w_cell_hit) begin
          w_state_nxt   = DONE;
          w_winner_nxt  = i_board[r_row][r_col];
          w_win_row_nxt = r_row;
          w_win_col_nxt = r_col;
          w_win_dir_nxt = w_dir;
        end else if (r_idx == IW'(NCELL - 1)) begin
          w_state_nxt = DONE;
          w_draw_nxt  = &w_top_nz;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_col == CW'(COLS - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and the single DONE cycle both accept a new scan.
        w_state_nxt = IDLE;
        if (i_start) begin
          w_state_nxt   = SCAN;
          w_idx_nxt     = '0;
          w_row_nxt     = '0;
          w_col_nxt     = '0;
          w_winner_nxt  = '0;
          w_draw_nxt    = 1'b0;
          w_win_row_nxt = '0;
          w_win_col_nxt = '0;
          w_win_dir_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_winner  <= '0;
      r_draw    <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
      r_win_dir <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_winner  <= w_winner_nxt;
      r_draw    <= w_draw_nxt;
      r_win_row <= w_win_row_nxt;
      r_win_col <= w_win_col_nxt;
      r_win_dir <= w_win_dir_nxt;
    end
  end

  assign o_busy    = (r_state == SCAN);
  assign o_done    = (r_state == DONE);
  assign o_winner  = r_winner;
  assign o_draw    = r_draw;
  assign o_win_row = 3'(r_win_row);
  assign o_win_col = 3'(r_win_col);
  assign o_win_dir = r_win_dir;

`ifdef WIN_CHECK_MASK_EN
  // A winning line is a fixed bit pattern per direction, shifted up to the anchor index.
  function automatic logic [NCELL-1:0] line_pat(input int step);
    logic [NCELL-1:0] p;
    p = '0;
    for (int k = 0; k < WIN_LEN; k++) p = p | (NCELL'(1) << (k * step));
    return p;
  endfunction

  localparam logic [NCELL-1:0] PAT_H  = line_pat(1);
  localparam logic [NCELL-1:0] PAT_V  = line_pat(COLS);
  localparam logic [NCELL-1:0] PAT_DR = line_pat(COLS + 1);
  localparam logic [NCELL-1:0] PAT_DL = line_pat(COLS - 1);

  logic [NCELL-1:0] r_win_mask, w_pat;

  assign w_pat = (w_dir == 2'd0) ? PAT_H  :
                 (w_dir == 2'd1) ? PAT_V  :
                 (w_dir == 2'd2) ? PAT_DR : PAT_DL;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_mask <= '0;
    end else if (r_state != SCAN && i_start) begin
      r_win_mask <= '0;
    end else if (r_state == SCAN && (|w_cell_hit)) begin
      r_win_mask <= w_pat << r_idx;
    end
  end

  assign o_win_mask = r_win_mask;
`endif
endmodule

// File: doc/win_checker.md
Name: win_checker

Overview:
- Sequential reader of the Connect-4 board array written by Board_Manager.
- Scans the board one cell per clock after each insertion and reports a winner, a draw, or no result.
- Reports the anchor cell and direction of the first winning line found.
- Sits between Board_Manager and the game-control FSM; the control FSM pulses start after every accepted insert and waits for done.

Parameters:
- ROWS, 6, board rows; row 0 is the top row, row ROWS-1 is the bottom row.
- COLS, 7, board columns.
- WIN_LEN, 4, run length that wins.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a scan; sampled on posedge only while busy=0.
- board  in  2 x [0:ROWS-1][0:COLS-1]  cell values: 0 empty, 1 player 1, 2 player 2, 3 invalid.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; scan finished, results valid.
- winner  out  2  0 none, 1 player 1, 2 player 2.
- draw  out  1  no winner and the board is full.
- win_row  out  3  anchor row of the winning line.
- win_col  out  3  anchor column of the winning line.
- win_dir  out  2  0 horizontal-right, 1 vertical-down, 2 diagonal down-right, 3 diagonal down-left.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE, idx=0. busy, done, winner, draw, win_row, win_col and win_dir are all 0.
- rst asserted mid-scan aborts the scan on the next edge. No done pulse is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE/DONE -> SCAN when start=1 at the edge:
  - idx <= 0, busy <= 1.
  - winner, draw, win_row, win_col and win_dir are cleared to 0.
  - start is also accepted during the DONE cycle.
- start while busy=1 is ignored.
- SCAN: each edge evaluates cell idx, with r = idx / COLS and c = idx % COLS.
  - A hit requires cell value 1 or 2, and the next WIN_LEN-1 cells in that direction hold the same value.
  - Directions are bounds-checked. Cells outside the board never match.
  - Direction priority within a cell: H, V, DR, DL.
  - On a hit: latch winner, win_row=r, win_col=c, win_dir; go to DONE.
  - On no hit at idx = ROWS*COLS-1: set draw=1 iff every row-0 cell is nonzero; go to DONE.
  - Otherwise idx <= idx+1.
  - busy stays 1 through the edge that leaves SCAN.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Results hold until the next accepted start or rst.
- Latency:
  - done is high in the cycle after the (k+1)-th edge following the start edge, where k is the row-major index of the anchor cell.
  - With no winner, done is high after 42 edges for the default 6x7 board.
- First hit wins. Row-major order with direction priority decides which line is reported when several exist.
- Value 3 cells never win and count as filled for the draw check.
- board must be held stable while busy=1; the control FSM must not insert during a scan. The checker does not detect changes to board during a scan.
- winner and draw are never both nonzero.

Optional Feature:
- Macro: WIN_CHECK_MASK_EN.
- When defined: adds output win_mask [ROWS*COLS-1:0].
  - Bit r*COLS+c is set for each of the WIN_LEN winning cells.
  - Updated in the same cycle as winner and cleared with it.
  - All zero on no win, on draw and on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 edges -> busy=0, done=0, winner=0, draw=0, win_row/col/dir=0. Empty board, then start -> done after 42 edges, winner=0, draw=0.
- Horizontal win: player 1 at row 5, cols 0-3; start -> done after 36 edges, winner=1, win_row=5, win_col=0, win_dir=0.
- Vertical win: player 2 at col 3, rows 2-5; start -> done after 18 edges, winner=2, win_row=2, win_col=3, win_dir=1.
- Diagonal down-left win: player 1 at (2,3), (3,2), (4,1), (5,0); start -> done after 18 edges, winner=1, anchor (2,3), win_dir=3. With WIN_CHECK_MASK_EN, win_mask bits 17, 23, 29, 35 are set.
- Full board, no win: cell=1 when (r+g(c)) is even, else 2, with g=0 for cols 0,1,4,5 and g=1 for cols 2,3,6; start -> done after 42 edges, winner=0, draw=1.
- Control corner cases:
  - start pulsed again at edge 5 of a scan -> ignored; single done at the normal time.
  - rst at edge 10 of a scan -> busy=0 next cycle, no done, outputs 0.
  - start in the DONE cycle -> new scan begins, busy=1.
